// File: rtl/addr_gen_pkg.sv
// Shared constants and the effective-dimension helper for the raster address generator.
package addr_gen_pkg;

  localparam int DIM_W   = 9;
  localparam int CNT_W   = 8;
  localparam int ADDR_W  = 17;
  localparam int MAX_DIM = 256;

  // Zero collapses to a 1x1 image; anything past MAX_DIM is clamped.
  function automatic logic [DIM_W-1:0] eff_dim(input logic [DIM_W-1:0] img_dim);
    if (img_dim == '0) begin
      return DIM_W'(1);
    end else if (img_dim > DIM_W'(MAX_DIM)) begin
      return DIM_W'(MAX_DIM);
    end else begin
      return img_dim;
    end
  endfunction

endpackage

// File: rtl/addr_gen_cnt.sv
// Wrapping counter: steps while enabled, returns to 0 once it has reached (or passed) limit.
module addr_gen_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q, count_d;

  // >= rather than == so a limit that drops below the count still wraps.
  assign wrap_o  = en_i && (count_q >= limit_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = wrap_o ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/addr_gen.sv
// Raster-scan address generator: x/y counters for a square image plus a linear
// address kept as an accumulator alongside x.
module addr_gen #(
  parameter int DIM_W  = addr_gen_pkg::DIM_W,
  parameter int CNT_W  = addr_gen_pkg::CNT_W,
  parameter int ADDR_W = addr_gen_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sclr,
  input  logic [DIM_W-1:0]  img_dim,
  output logic [ADDR_W-1:0] addr_out,
  output logic [CNT_W-1:0]  x_cnt,
  output logic [CNT_W-1:0]  y_cnt
);

  import addr_gen_pkg::*;

  logic [DIM_W-1:0]  dim_eff;
  logic [CNT_W-1:0]  limit;
  logic              x_wrap, y_wrap, y_en, frame_wrap;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign dim_eff = eff_dim(img_dim);
  assign limit   = CNT_W'(dim_eff - DIM_W'(1));

  addr_gen_cnt #(.W(CNT_W)) u_x_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en),
    .clr_i   (sclr),
    .limit_i (limit),
    .count_o (x_cnt),
    .wrap_o  (x_wrap)
  );

  assign y_en = en && x_wrap;

  addr_gen_cnt #(.W(CNT_W)) u_y_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (y_en),
    .clr_i   (sclr),
    .limit_i (limit),
    .count_o (y_cnt),
    .wrap_o  (y_wrap)
  );

  // Address resynchronises to 0 only on clear or a full-frame wrap.
  assign frame_wrap = x_wrap && y_wrap;

  always_comb begin
    addr_d = addr_q;
    if (sclr) begin
      addr_d = '0;
    end else if (en) begin
      addr_d = frame_wrap ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_out = addr_q;

endmodule

// File: tb/tb_addr_gen.sv
// Bench for addr_gen: vector table, directed multi-cycle sequences, and a
// randomized run against a pixel-index reference model.
module tb_addr_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sclr = 1'b0;
  logic [8:0]  img_dim = 9'd4;
  logic [16:0] addr_out;
  logic [7:0]  x_cnt, y_cnt;

  int tests = 0;
  int fails = 0;

  addr_gen dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sclr     (sclr),
    .img_dim  (img_dim),
    .addr_out (addr_out),
    .x_cnt    (x_cnt),
    .y_cnt    (y_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       s;
    logic       e;
    logic [8:0] d;
    int         ex;
    int         ey;
    int         ea;
  } vec_t;

  vec_t vecs[16];

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic drive(input logic r, input logic s, input logic e, input logic [8:0] d);
    rst = r; sclr = s; en = e; img_dim = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int ex, input int ey, input int ea);
    tests++;
    if (int'(x_cnt) != ex || int'(y_cnt) != ey || int'(addr_out) != ea) begin
      fails++;
      $display("FAIL %s: got x=%0d y=%0d addr=%0d, expected x=%0d y=%0d addr=%0d",
               name, x_cnt, y_cnt, addr_out, ex, ey, ea);
    end else begin
      $display("[TB] %s: x=%0d y=%0d addr=%0d ok", name, x_cnt, y_cnt, addr_out);
    end
  endtask

  function automatic int effd(input int d);
    if (d == 0) return 1;
    if (d > 256) return 256;
    return d;
  endfunction

  initial begin
    int p, dd, k, idx;
    logic r, s, e;
    logic [8:0] d;
    int dims[10] = '{0, 1, 2, 3, 4, 5, 7, 16, 300, 256};

    // Single-cycle vectors: each row is one edge, expectation is after that edge.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 9'd4, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 9'd4, 0, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 9'd4, 1, 0, 1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 9'd4, 2, 0, 2};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 9'd4, 3, 0, 3};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 9'd4, 0, 1, 4};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 9'd4, 0, 1, 4};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 9'd4, 1, 1, 5};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 9'd4, 0, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 9'd1, 0, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 9'd1, 0, 0, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 9'd0, 0, 0, 0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 9'd2, 1, 0, 1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 9'd2, 0, 1, 2};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 9'd2, 1, 1, 3};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 9'd2, 0, 0, 0};

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].e, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ea);
    end

    // Full 16x16 frame with intermediate row-wrap check.
    drive(1'b0, 1'b1, 1'b0, 9'd16);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b1, 9'd16);
    check("dim16_row_wrap", 0, 1, 16);
    for (int i = 16; i < 255; i++) drive(1'b0, 1'b0, 1'b1, 9'd16);
    check("dim16_last_pixel", 15, 15, 255);
    drive(1'b0, 1'b0, 1'b1, 9'd16);
    check("dim16_frame_wrap", 0, 0, 0);

    // Clear mid-frame with en high, then hold clear with en low.
    for (int i = 0; i < 53; i++) drive(1'b0, 1'b0, 1'b1, 9'd16);
    check("dim16_midframe", 5, 3, 53);
    drive(1'b0, 1'b1, 1'b1, 9'd16);
    check("sclr_with_en", 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 9'd16);
      check($sformatf("sclr_held%0d", i), 0, 0, 0);
    end

    // en toggling every cycle, 4x4 image.
    k = 0;
    for (int i = 0; i < 32; i++) begin
      e = (i % 2 == 0);
      drive(1'b0, 1'b0, e, 9'd4);
      if (e) k++;
      idx = k % 16;
      check($sformatf("toggle%0d", i), idx % 4, idx / 4, idx);
    end

    // Shrink 16 -> 8 while x=12.
    drive(1'b0, 1'b1, 1'b0, 9'd16);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b1, 9'd16);
    check("shrink_before", 12, 0, 12);
    drive(1'b0, 1'b0, 1'b1, 9'd8);
    check("shrink_wrap", 0, 1, 13);
    drive(1'b0, 1'b0, 1'b1, 9'd8);
    check("shrink_after", 1, 1, 14);

    // Reset mid-frame with en high.
    drive(1'b1, 1'b0, 1'b1, 9'd8);
    check("rst_midframe", 0, 0, 0);

    // Oversize dimension clamps to 256.
    drive(1'b0, 1'b1, 1'b0, 9'd300);
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b0, 1'b1, 9'd300);
    check("dim300_clamp", 44, 1, 300);

    // Largest frame: 256x256.
    drive(1'b0, 1'b1, 1'b0, 9'd256);
    for (int i = 0; i < 65535; i++) drive(1'b0, 1'b0, 1'b1, 9'd256);
    check("dim256_last_pixel", 255, 255, 65535);
    drive(1'b0, 1'b0, 1'b1, 9'd256);
    check("dim256_frame_wrap", 0, 0, 0);

    // Randomized run. Model: p counts enabled steps since the last clear, modulo D*D;
    // x = p mod D, y = p div D, addr = p. Dimension changes always come with a clear.
    d = 9'd5;
    drive(1'b1, 1'b0, 1'b0, d);
    p = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom % 64 == 0);
      s = ($urandom % 24 == 0);
      e = ($urandom % 4 != 0);
      if ($urandom % 40 == 0) begin
        if ($urandom % 3 == 0) d = 9'($urandom_range(1, 20));
        else d = 9'(dims[$urandom % 10]);
        s = 1'b1;
      end
      drive(r, s, e, d);
      dd = effd(int'(d));
      if (r || s) p = 0;
      else if (e) p = (p + 1) % (dd * dd);
      check($sformatf("rand%0d_d%0d", i, dd), p % dd, p / dd, p);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
